// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: programmable preset, optional auto-reload, maskable level interrupt.
// Define TIMER_IRQ_EN to build the interrupt path (CTRL.IM, irq_pend, irq); otherwise irq is tied low.
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam int unsigned DW = 32;

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;
  localparam logic [1:0] M_RELOAD = 2'b01;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t        state;
  logic          en;
  logic [1:0]    mode;
  logic          im;
  logic [DW-1:0] preset;
  logic [DW-1:0] count;

  logic ctrl_wr;
  logic preset_wr;
  logic expire;

  assign ctrl_wr   = we && (addr == A_CTRL);
  assign preset_wr = we && (addr == A_PRESET);
  // Final counting cycle: the transition into INT happens on this edge.
  assign expire    = (state == CNT) && en && (count <= DW'(1));

  // Register file and countdown FSM; a CPU CTRL write overrides the FSM's En clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      preset <= '0;
      count  <= '0;
    end else begin
      if (preset_wr) preset <= din;
      if (ctrl_wr) begin
        en   <= din[0];
        mode <= din[2:1];
      end
      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (expire) begin
            count <= '0;
            state <= INT;
          end else begin
            count <= count - DW'(1);
          end
        end
        INT: begin
          if (mode == M_RELOAD) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            if (!ctrl_wr) en <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_pend;

  // Pending flag: expiry set takes priority over the clear caused by any CTRL write.
  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= 1'b0;
      irq_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        im       <= din[3];
        irq_pend <= 1'b0;
      end
      if (expire) irq_pend <= 1'b1;
      irq <= irq_pend & im;
    end
  end
`else
  assign im  = 1'b0;
  assign irq = 1'b0;
`endif

  // Zero-latency, side-effect-free read mux.
  always_comb begin
    dout = '0;
    case (addr)
      A_CTRL:   dout = {28'd0, im, mode, en};
      A_PRESET: dout = preset;
      A_COUNT:  dout = count;
      default:  dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: expectations are queued as stimulus is applied and drained cycle by cycle.
module tb_timer_dev;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

`ifdef TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam logic [1:0] A_CTRL   = 2'b00;
  localparam logic [1:0] A_PRESET = 2'b01;
  localparam logic [1:0] A_COUNT  = 2'b10;
  localparam logic [1:0] A_RES    = 2'b11;

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          adv;
    bit          is_irq;
    logic [1:0]  a;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   total = 0;

  function automatic logic [31:0] ctrl_exp(input logic [31:0] v);
    return IRQ_ON ? v : (v & 32'h7);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    cyc(1);
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic push_rd(input string tag, input int adv, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.adv = adv; e.is_irq = 1'b0; e.a = a; e.v = v;
    sb.push_back(e);
  endtask

  task automatic push_irq(input string tag, input int adv, input logic v);
    exp_t e;
    e.tag = tag; e.adv = adv; e.is_irq = 1'b1; e.a = A_RES; e.v = {31'd0, v};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.adv > 0) cyc(e.adv);
      if (e.is_irq) begin
        obs = {31'd0, irq};
      end else begin
        addr = e.a;
        #1;
        obs = dout;
      end
      total++;
      assert (obs === e.v) npass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; we = 1'b1; din = 32'hFFFF_FFFF; addr = A_CTRL;
    cyc(2);
    rst = 1'b0; we = 1'b0; din = '0;
    push_rd("rst_ctrl", 0, A_CTRL, 32'd0);
    push_rd("rst_preset", 0, A_PRESET, 32'd0);
    push_rd("rst_count", 0, A_COUNT, 32'd0);
    push_rd("rst_res", 0, A_RES, 32'd0);
    push_irq("rst_irq", 0, 1'b0);
    push_rd("rst_idle", 3, A_COUNT, 32'd0);
    drain();

    wr(A_PRESET, 32'hDEAD_BEEF);
    push_rd("preset_rb", 0, A_PRESET, 32'hDEAD_BEEF);
    drain();

    // One-shot N=5 with IM: LOAD edge 1, COUNT=5 edge 2, INT edge 7, irq edge 8.
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    push_rd("os_ctrl", 0, A_CTRL, ctrl_exp(32'h9));
    push_rd("os_load", 1, A_COUNT, 32'd0);
    for (int k = 5; k >= 1; k--) push_rd("os_cnt", 1, A_COUNT, 32'(k));
    push_rd("os_zero", 1, A_COUNT, 32'd0);
    push_irq("os_irq_pre", 0, 1'b0);
    push_irq("os_irq_rise", 1, IRQ_ON);
    push_rd("os_ctrl_done", 0, A_CTRL, ctrl_exp(32'h8));
    push_irq("os_irq_hold", 3, IRQ_ON);
    push_rd("os_cnt_hold", 0, A_COUNT, 32'd0);
    drain();
    wr(A_CTRL, 32'h8);
    push_irq("os_irq_lag", 0, IRQ_ON);
    push_irq("os_irq_drop", 1, 1'b0);
    drain();

    // Auto-reload N=3: INT at edges 5 and 10.
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    push_rd("ar_load", 1, A_COUNT, 32'd0);
    push_rd("ar_c3", 1, A_COUNT, 32'd3);
    push_rd("ar_c2", 1, A_COUNT, 32'd2);
    push_rd("ar_c1", 1, A_COUNT, 32'd1);
    push_rd("ar_c0", 1, A_COUNT, 32'd0);
    push_irq("ar_irq_pre", 0, 1'b0);
    push_rd("ar_reload", 1, A_COUNT, 32'd0);
    push_irq("ar_irq", 0, IRQ_ON);
    push_rd("ar2_c3", 1, A_COUNT, 32'd3);
    push_rd("ar2_c2", 1, A_COUNT, 32'd2);
    push_rd("ar2_c1", 1, A_COUNT, 32'd1);
    push_rd("ar2_c0", 1, A_COUNT, 32'd0);
    push_rd("ar2_reload", 1, A_COUNT, 32'd0);
    push_rd("ar3_c3", 1, A_COUNT, 32'd3);
    drain();

    // Clear pending, then write CTRL on the exact edge INT is entered.
    wr(A_CTRL, 32'hB);
    push_rd("col_c2", 0, A_COUNT, 32'd2);
    push_irq("col_irq_lag", 0, IRQ_ON);
    push_irq("col_irq_clr", 1, 1'b0);
    push_rd("col_c1", 0, A_COUNT, 32'd1);
    drain();
    wr(A_CTRL, 32'hB);
    push_rd("col_c0", 0, A_COUNT, 32'd0);
    push_irq("col_set_wins", 1, IRQ_ON);
    drain();

    // Switch to one-shot, then write CTRL while in INT: En must survive.
    wr(A_CTRL, 32'h9);
    push_rd("os2_c3", 0, A_COUNT, 32'd3);
    push_rd("os2_c2", 1, A_COUNT, 32'd2);
    push_rd("os2_c1", 1, A_COUNT, 32'd1);
    push_rd("os2_c0", 1, A_COUNT, 32'd0);
    drain();
    wr(A_CTRL, 32'h9);
    push_rd("en_wins_ctrl", 0, A_CTRL, ctrl_exp(32'h9));
    push_irq("en_wins_irq", 0, IRQ_ON);
    push_irq("en_wins_irq_clr", 1, 1'b0);
    push_rd("en_wins_load", 0, A_COUNT, 32'd0);
    push_rd("en_wins_c3", 1, A_COUNT, 32'd3);
    push_rd("en_wins_c2", 1, A_COUNT, 32'd2);
    push_rd("en_wins_c1", 1, A_COUNT, 32'd1);
    push_rd("en_wins_c0", 1, A_COUNT, 32'd0);
    push_rd("en_wins_done", 1, A_CTRL, ctrl_exp(32'h8));
    push_irq("en_wins_irq2", 0, IRQ_ON);
    drain();
    wr(A_CTRL, 32'h0);
    push_irq("irq_off", 2, 1'b0);
    drain();

    // PRESET change mid-count is deferred; clearing En freezes COUNT.
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    push_rd("mid_load", 1, A_COUNT, 32'd0);
    for (int k = 10; k >= 7; k--) push_rd("mid_cnt", 1, A_COUNT, 32'(k));
    drain();
    wr(A_PRESET, 32'd2);
    push_rd("mid_c6", 0, A_COUNT, 32'd6);
    push_rd("mid_preset", 0, A_PRESET, 32'd2);
    push_rd("mid_c5", 1, A_COUNT, 32'd5);
    drain();
    wr(A_CTRL, 32'h0);
    push_rd("stop_c4", 0, A_COUNT, 32'd4);
    push_rd("stop_hold1", 1, A_COUNT, 32'd4);
    push_rd("stop_hold2", 1, A_COUNT, 32'd4);
    push_rd("stop_hold3", 3, A_COUNT, 32'd4);
    push_rd("stop_ctrl", 0, A_CTRL, 32'd0);
    drain();
    wr(A_CTRL, 32'h1);
    push_rd("re_c4", 0, A_COUNT, 32'd4);
    push_rd("re_load", 1, A_COUNT, 32'd4);
    push_rd("re_c2", 1, A_COUNT, 32'd2);
    push_rd("re_c1", 1, A_COUNT, 32'd1);
    push_rd("re_c0", 1, A_COUNT, 32'd0);
    push_rd("re_ctrl", 1, A_CTRL, 32'd0);
    push_irq("re_irq_masked", 0, 1'b0);
    drain();

    // PRESET 0 and 1 both reach INT at edge 3.
    for (int p = 0; p < 2; p++) begin
      wr(A_PRESET, 32'(p));
      wr(A_CTRL, 32'h9);
      push_rd("small_load", 1, A_COUNT, 32'd0);
      push_rd("small_cnt", 1, A_COUNT, 32'(p));
      push_rd("small_zero", 1, A_COUNT, 32'd0);
      push_rd("small_int_ctrl", 0, A_CTRL, ctrl_exp(32'h9));
      push_irq("small_irq_pre", 0, 1'b0);
      push_rd("small_idle_ctrl", 1, A_CTRL, ctrl_exp(32'h8));
      push_irq("small_irq", 0, IRQ_ON);
      drain();
      wr(A_CTRL, 32'h0);
      push_irq("small_irq_clr", 1, 1'b0);
      drain();
    end

    // Read-only and reserved writes change nothing.
    wr(A_PRESET, 32'd7);
    wr(A_COUNT, 32'h1234);
    wr(A_RES, 32'hFFFF_FFFF);
    push_rd("ro_count", 0, A_COUNT, 32'd0);
    push_rd("ro_res", 0, A_RES, 32'd0);
    push_rd("ro_ctrl", 0, A_CTRL, 32'd0);
    push_rd("ro_preset", 0, A_PRESET, 32'd7);
    push_rd("ro_idle", 2, A_COUNT, 32'd0);
    drain();

    // Mode 11 behaves as one-shot; CTRL upper bits read 0.
    wr(A_CTRL, 32'hFFFF_FFFF);
    push_rd("m3_ctrl", 0, A_CTRL, ctrl_exp(32'hF));
    push_rd("m3_load", 1, A_COUNT, 32'd0);
    for (int k = 7; k >= 1; k--) push_rd("m3_cnt", 1, A_COUNT, 32'(k));
    push_rd("m3_zero", 1, A_COUNT, 32'd0);
    push_rd("m3_done", 1, A_CTRL, ctrl_exp(32'hE));
    push_irq("m3_irq", 0, IRQ_ON);
    push_rd("m3_no_reload", 2, A_COUNT, 32'd0);
    drain();
    wr(A_CTRL, 32'h0);
    push_irq("m3_irq_clr", 1, 1'b0);
    drain();

    // Reset mid-count discards the count and never raises irq.
    wr(A_PRESET, 32'd6);
    wr(A_CTRL, 32'h9);
    push_rd("rm_c4", 4, A_COUNT, 32'd4);
    drain();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    push_rd("rm_ctrl", 0, A_CTRL, 32'd0);
    push_rd("rm_preset", 0, A_PRESET, 32'd0);
    push_rd("rm_count", 0, A_COUNT, 32'd0);
    push_irq("rm_irq", 0, 1'b0);
    push_rd("rm_count_late", 8, A_COUNT, 32'd0);
    push_irq("rm_irq_late", 0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
